// File: rtl/clock_divider_pkg.sv
// Shared types and clamp helpers for multi_clock_divider.
// Optional macro CLKDIV_DUTY_EN adds clamp_duty for a programmable high phase.
package clock_divider_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam int RATIO_MIN = 2;

  // Helpers run at 64 bits so any RATIO_W up to 64 can cast in and out.
  function automatic logic [63:0] clamp_ratio(input logic [63:0] r);
    return (r < 64'(RATIO_MIN)) ? 64'(RATIO_MIN) : r;
  endfunction

`ifdef CLKDIV_DUTY_EN
  // Keep at least one high and one low cycle in every period.
  function automatic logic [63:0] clamp_duty(input logic [63:0] d,
                                             input logic [63:0] r);
    if (d < 64'd1)      return 64'd1;
    else if (d > r - 1) return r - 1;
    else                return d;
  endfunction
`endif

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: IDLE/RUN FSM, period counter and registered outputs.
// Macro CLKDIV_DUTY_EN adds a duty input that sets the high-phase length.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int RATIO_W = 32
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               sync,
  input  logic [RATIO_W-1:0] ratio,
`ifdef CLKDIV_DUTY_EN
  input  logic [RATIO_W-1:0] duty,
`endif
  output logic               clk_out,
  output logic               tick,
  output logic               active
);

  state_e             state_q, state_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [RATIO_W-1:0] act_q, act_d;
  logic [RATIO_W-1:0] h_q, h_d;
  logic               clk_q, clk_d;
  logic               tick_q, tick_d;
  logic [RATIO_W-1:0] eff_ratio;
  logic [RATIO_W-1:0] eff_h;
  logic               start;

  assign eff_ratio = RATIO_W'(clamp_ratio(64'(ratio)));
`ifdef CLKDIV_DUTY_EN
  assign eff_h = RATIO_W'(clamp_duty(64'(duty), 64'(eff_ratio)));
`else
  assign eff_h = eff_ratio >> 1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    h_d     = h_q;
    clk_d   = 1'b0;
    tick_d  = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) start = 1'b1;
      end
      RUN: begin
        if (sync) begin
          start = 1'b1;
        end else if (cnt_q == act_q - RATIO_W'(1)) begin
          // Period boundary: reload or retire, never cut a period short.
          if (enable) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + RATIO_W'(1);
          clk_d = (cnt_q + RATIO_W'(1)) < h_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = RUN;
      act_d   = eff_ratio;
      h_d     = eff_h;
      cnt_d   = '0;
      clk_d   = 1'b1;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      act_q   <= RATIO_W'(RATIO_MIN);
      h_q     <= RATIO_W'(RATIO_MIN / 2);
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      h_q     <= h_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign active  = (state_q == RUN);

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent clock dividers sharing clk_in, reset and sync.
// Macro CLKDIV_DUTY_EN adds a per-channel duty vector packed like ratio.
module multi_clock_divider
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int RATIO_W = 32
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         enable,
  input  logic [NUM_CH*RATIO_W-1:0] ratio,
`ifdef CLKDIV_DUTY_EN
  input  logic [NUM_CH*RATIO_W-1:0] duty,
`endif
  input  logic                      sync,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         active
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clock_divider_channel #(.RATIO_W(RATIO_W)) u_ch (
      .clk_in  (clk_in),
      .rst_n   (reset),
      .enable  (enable[i]),
      .sync    (sync),
      .ratio   (ratio[i*RATIO_W +: RATIO_W]),
`ifdef CLKDIV_DUTY_EN
      .duty    (duty[i*RATIO_W +: RATIO_W]),
`endif
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .active  (active[i])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Randomised and directed bench for multi_clock_divider against a period-position model.
module tb_multi_clock_divider;
  localparam int NCH = 4;
  localparam int RW  = 16;

  logic                clk_in = 1'b0;
  logic                reset  = 1'b0;
  logic [NCH-1:0]      en     = '0;
  logic [NCH*RW-1:0]   rat    = '0;
  logic [NCH*RW-1:0]   dty    = '0;
  logic                sync   = 1'b0;
  logic [NCH-1:0]      clk_out, tick, active;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Model: each channel is either stopped, or at position pos within a
  // period of length per whose first hi cycles are high.
  bit m_run [NCH];
  int m_pos [NCH];
  int m_per [NCH];
  int m_hi  [NCH];

  always #5 clk_in = ~clk_in;

  multi_clock_divider #(.NUM_CH(NCH), .RATIO_W(RW)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .enable  (en),
    .ratio   (rat),
`ifdef CLKDIV_DUTY_EN
    .duty    (dty),
`endif
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .active  (active)
  );

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_per[i] = 2; m_hi[i] = 1;
    end
  endfunction

  function automatic void model_start(int i);
    int r;
    r = int'(rat[i*RW +: RW]);
    if (r < 2) r = 2;
    m_per[i] = r;
`ifdef CLKDIV_DUTY_EN
    m_hi[i] = int'(dty[i*RW +: RW]);
    if (m_hi[i] < 1) m_hi[i] = 1;
    if (m_hi[i] > r - 1) m_hi[i] = r - 1;
`else
    m_hi[i] = r / 2;
`endif
    m_pos[i] = 0;
    m_run[i] = 1;
  endfunction

  function automatic void model_step();
    if (!reset) begin model_reset(); return; end
    for (int i = 0; i < NCH; i++) begin
      if (!m_run[i]) begin
        if (en[i]) model_start(i);
      end else if (sync) begin
        model_start(i);
      end else if (m_pos[i] == m_per[i] - 1) begin
        if (en[i]) model_start(i);
        else m_run[i] = 0;
      end else begin
        m_pos[i]++;
      end
    end
  endfunction

  // Expected {clk_out, tick, active} derived from the model position.
  function automatic logic [3*NCH-1:0] exp_vec();
    logic [NCH-1:0] c, t, a;
    for (int i = 0; i < NCH; i++) begin
      a[i] = m_run[i];
      c[i] = m_run[i] && (m_pos[i] < m_hi[i]);
      t[i] = m_run[i] && (m_pos[i] == 0);
    end
    return {c, t, a};
  endfunction

  task automatic step();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    en = '0; sync = 1'b0; reset = 1'b0;
    model_reset();
    step(); step();
    reset = 1'b1;
  endtask

  task automatic set_ratio(int i, int r);
    rat[i*RW +: RW] = RW'(r);
  endtask

  task automatic test_reset();
    reset = 1'b0; #2;
    cmp_cnt++;
    if ({clk_out, tick, active} !== '0) begin
      err_cnt++; $display("FAIL reset_async: got %b want 0", {clk_out, tick, active});
    end
    do_reset();
    cmp_cnt++;
    if ({clk_out, tick, active} !== exp_vec()) begin
      err_cnt++; $display("FAIL reset_release: got %b want %b", {clk_out, tick, active}, exp_vec());
    end
  endtask

  task automatic test_ratio4();
    do_reset();
    set_ratio(0, 4); en[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      cmp_cnt++;
      if (clk_out[0] !== ((k % 4) < 2) || tick[0] !== ((k % 4) == 0) || active[0] !== 1'b1) begin
        err_cnt++; $display("FAIL ratio4 k=%0d: clk/tick/act got %b%b%b", k, clk_out[0], tick[0], active[0]);
      end
      cmp_cnt++;
      if ({clk_out, tick, active} !== exp_vec()) begin
        err_cnt++; $display("FAIL ratio4_model k=%0d: got %b want %b", k, {clk_out, tick, active}, exp_vec());
      end
    end
  endtask

  task automatic test_odd_and_clamp();
    int rs[3] = '{5, 0, 1};
    foreach (rs[j]) begin
      do_reset();
      set_ratio(0, rs[j]); en[0] = 1'b1;
      for (int k = 0; k < 15; k++) begin
        step();
        cmp_cnt++;
        if (rs[j] == 5 ? (clk_out[0] !== ((k % 5) < 2)) : (clk_out[0] !== ((k % 2) == 0))) begin
          err_cnt++; $display("FAIL odd_clamp r=%0d k=%0d: got %b", rs[j], k, clk_out[0]);
        end
        cmp_cnt++;
        if ({clk_out, tick, active} !== exp_vec()) begin
          err_cnt++; $display("FAIL odd_clamp_model r=%0d k=%0d: got %b want %b", rs[j], k, {clk_out, tick, active}, exp_vec());
        end
      end
    end
  endtask

  task automatic test_ratio_change();
    do_reset();
    set_ratio(0, 4); en[0] = 1'b1;
    step();            // cnt = 0
    step();            // cnt = 1
    set_ratio(0, 6);
    for (int k = 2; k < 16; k++) begin
      step();
      cmp_cnt++;
      if (clk_out[0] !== (k < 4 ? (k < 2) : (((k - 4) % 6) < 3))) begin
        err_cnt++; $display("FAIL ratio_change k=%0d: got %b", k, clk_out[0]);
      end
      cmp_cnt++;
      if ({clk_out, tick, active} !== exp_vec()) begin
        err_cnt++; $display("FAIL ratio_change_model k=%0d: got %b want %b", k, {clk_out, tick, active}, exp_vec());
      end
    end
  endtask

  task automatic test_disable();
    do_reset();
    set_ratio(0, 8); en[0] = 1'b1;
    step();            // cnt = 0
    en[0] = 1'b0;
    for (int k = 1; k < 11; k++) begin
      step();
      cmp_cnt++;
      if (clk_out[0] !== (k < 4) || active[0] !== (k < 8) || tick[0] !== 1'b0) begin
        err_cnt++; $display("FAIL disable k=%0d: clk/tick/act got %b%b%b", k, clk_out[0], tick[0], active[0]);
      end
    end
    // Async reset in the middle of a high phase.
    en[0] = 1'b1; step();
    #2 reset = 1'b0; #1;
    cmp_cnt++;
    if (clk_out[0] !== 1'b0 || active[0] !== 1'b0) begin
      err_cnt++; $display("FAIL reset_mid_high: clk %b act %b want 0 0", clk_out[0], active[0]);
    end
    model_reset();
    en = '0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_sync();
    do_reset();
    set_ratio(0, 4); set_ratio(1, 6); set_ratio(2, 3);
    en = 4'b0011;
    repeat (3) step();
    sync = 1'b1; step(); sync = 1'b0;
    cmp_cnt++;
    if (tick[1:0] !== 2'b11 || clk_out[1:0] !== 2'b11 || clk_out[2] !== 1'b0 || active[2] !== 1'b0) begin
      err_cnt++; $display("FAIL sync_align: tick %b clk %b act %b", tick, clk_out, active);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      cmp_cnt++;
      if ({clk_out, tick, active} !== exp_vec()) begin
        err_cnt++; $display("FAIL sync_model k=%0d: got %b want %b", k, {clk_out, tick, active}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < NCH; i++) set_ratio(i, $urandom_range(0, 9));
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 7) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) set_ratio($urandom_range(0, NCH - 1), $urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) dty[$urandom_range(0, NCH - 1)*RW +: RW] = RW'($urandom_range(0, 11));
      sync = ($urandom_range(0, 24) == 0);
      step();
      cmp_cnt++;
      if ({clk_out, tick, active} !== exp_vec()) begin
        err_cnt++; $display("FAIL random k=%0d: got %b want %b", k, {clk_out, tick, active}, exp_vec());
      end
    end
    sync = 1'b0;
  endtask

`ifdef CLKDIV_DUTY_EN
  task automatic test_duty();
    int ds[3]  = '{3, 0, 12};
    int his[3] = '{3, 1, 9};
    int hc;
    foreach (ds[j]) begin
      do_reset();
      set_ratio(0, 10); dty[0 +: RW] = RW'(ds[j]); en[0] = 1'b1;
      hc = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        hc += int'(clk_out[0]);
        cmp_cnt++;
        if ({clk_out, tick, active} !== exp_vec()) begin
          err_cnt++; $display("FAIL duty_model d=%0d k=%0d: got %b want %b", ds[j], k, {clk_out, tick, active}, exp_vec());
        end
      end
      cmp_cnt++;
      if (hc != his[j]) begin
        err_cnt++; $display("FAIL duty_high d=%0d: got %0d high want %0d", ds[j], hc, his[j]);
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_ratio4();
    test_odd_and_clamp();
    test_ratio_change();
    test_disable();
    test_sync();
`ifdef CLKDIV_DUTY_EN
    test_duty();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
